// File: rtl/rr_req_collector.sv
// Per-requester pending-request counters feeding a round-robin arbiter.
// Pulses are accumulated, grants retire them; drops and bad grants are sticky.
module rr_req_collector #(
    parameter int REQCNT   = 5,
    parameter int REQWIDTH = $clog2(REQCNT),
    parameter int CNTW     = 4,
    parameter int TOTW     = CNTW + $clog2(REQCNT + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [REQCNT-1:0]   req_pulse_i,
    input  logic [REQWIDTH-1:0] grant_num_i,
    input  logic                grant_val_i,
    input  logic [REQCNT-1:0]   ovf_clr_i,
    input  logic                err_clr_i,
    output logic [REQCNT-1:0]   req_o,
    output logic                req_val_o,
    output logic [TOTW-1:0]     pend_total_o,
    output logic [REQCNT-1:0]   ovf_o,
    output logic                err_o
);

    localparam logic [CNTW-1:0] MAX = '1;

    logic [REQCNT-1:0][CNTW-1:0] cnt;
    logic [REQCNT-1:0][CNTW-1:0] cnt_nxt;
    logic [REQCNT-1:0]           inc;
    logic [REQCNT-1:0]           dec;
    logic [REQCNT-1:0]           drop;
    logic [REQCNT-1:0]           req_nxt;
    logic [REQCNT-1:0]           ovf_nxt;
    logic [TOTW-1:0]             add;
    logic [TOTW-1:0]             tot_nxt;
    logic                        bad;
    logic                        err_nxt;

    always_comb begin
        cnt_nxt = cnt;
        inc     = '0;
        dec     = '0;
        drop    = '0;
        req_nxt = '0;
        add     = '0;
        for (int i = 0; i < REQCNT; i++) begin
            dec[i] = grant_val_i
                   && (grant_num_i == REQWIDTH'(i))
                   && (cnt[i] != '0);
            // A same-cycle retire frees a slot, so MAX can still accept.
            inc[i] = req_pulse_i[i]
                   && ((cnt[i] != MAX) || dec[i]);
            drop[i] = req_pulse_i[i] && !inc[i];
            if (inc[i] && !dec[i]) begin
                cnt_nxt[i] = cnt[i] + CNTW'(1);
            end else if (dec[i] && !inc[i]) begin
                cnt_nxt[i] = cnt[i] - CNTW'(1);
            end
            req_nxt[i] = (cnt_nxt[i] != '0);
            add = add + TOTW'(inc[i]);
        end
    end

    // dec can never be set for an out-of-range or empty requester.
    assign bad     = grant_val_i && !(|dec);
    assign tot_nxt = pend_total_o + add - TOTW'(|dec);
    assign ovf_nxt = drop | (ovf_o & ~ovf_clr_i);
    assign err_nxt = bad | (err_o & ~err_clr_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt          <= '0;
            req_o        <= '0;
            req_val_o    <= 1'b0;
            pend_total_o <= '0;
            ovf_o        <= '0;
            err_o        <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            req_o        <= req_nxt;
            req_val_o    <= |req_nxt;
            pend_total_o <= tot_nxt;
            ovf_o        <= ovf_nxt;
            err_o        <= err_nxt;
        end
    end

endmodule

// File: tb/tb_rr_req_collector.sv
// Directed vector bench for rr_req_collector.
// Each step drives inputs for one edge and checks the registered outputs.
module tb_rr_req_collector;

    localparam int N  = 5;
    localparam int RW = 3;
    localparam int TW = 7;

    logic          clk;
    logic          rst;
    logic [N-1:0]  pulse;
    logic [RW-1:0] gnum;
    logic          gval;
    logic [N-1:0]  oclr;
    logic          eclr;
    logic [N-1:0]  req;
    logic          rval;
    logic [TW-1:0] tot;
    logic [N-1:0]  ovf;
    logic          err;

    int applied = 0;
    int fails   = 0;

    typedef struct packed {
        logic          rst;
        logic [N-1:0]  pulse;
        logic [RW-1:0] gnum;
        logic          gval;
        logic [N-1:0]  oclr;
        logic          eclr;
        logic [N-1:0]  req;
        logic          rval;
        logic [TW-1:0] tot;
        logic [N-1:0]  ovf;
        logic          err;
    } vec_t;

    vec_t tbl[$];

    rr_req_collector dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_pulse_i  (pulse),
        .grant_num_i  (gnum),
        .grant_val_i  (gval),
        .ovf_clr_i    (oclr),
        .err_clr_i    (eclr),
        .req_o        (req),
        .req_val_o    (rval),
        .pend_total_o (tot),
        .ovf_o        (ovf),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [N-1:0] p,
                        input logic [RW-1:0] gn, input logic gv,
                        input logic [N-1:0] oc, input logic ec);
        rst   = r;
        pulse = p;
        gnum  = gn;
        gval  = gv;
        oclr  = oc;
        eclr  = ec;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        pulse = '0;
        gval  = 1'b0;
        oclr  = '0;
        eclr  = 1'b0;
    endtask

    task automatic check(input string name, input logic [N-1:0] e_req,
                         input logic e_val, input logic [TW-1:0] e_tot,
                         input logic [N-1:0] e_ovf, input logic e_err);
        applied++;
        if (req !== e_req || rval !== e_val || tot !== e_tot ||
            ovf !== e_ovf || err !== e_err) begin
            fails++;
            $display("FAIL %s: got req=%b val=%b tot=%0d ovf=%b err=%b, want req=%b val=%b tot=%0d ovf=%b err=%b",
                     name, req, rval, tot, ovf, err,
                     e_req, e_val, e_tot, e_ovf, e_err);
        end
    endtask

    initial begin
        rst = 1'b0; pulse = '0; gnum = '0; gval = 1'b0;
        oclr = '0; eclr = 1'b0;
        @(posedge clk); #1;

        //         rst pulse     gn gv oclr     ec  req       v  tot  ovf      err
        tbl.push_back('{1, 5'b11111, 0, 1, 5'b00000, 0, 5'b00000, 0, 0, 5'b00000, 0});
        tbl.push_back('{0, 5'b00101, 0, 0, 5'b00000, 0, 5'b00101, 1, 2, 5'b00000, 0});
        tbl.push_back('{0, 5'b00000, 0, 1, 5'b00000, 0, 5'b00100, 1, 1, 5'b00000, 0});
        tbl.push_back('{0, 5'b00000, 2, 1, 5'b00000, 0, 5'b00000, 0, 0, 5'b00000, 0});
        tbl.push_back('{0, 5'b00010, 0, 0, 5'b00000, 0, 5'b00010, 1, 1, 5'b00000, 0});
        tbl.push_back('{0, 5'b00010, 0, 0, 5'b00000, 0, 5'b00010, 1, 2, 5'b00000, 0});
        tbl.push_back('{0, 5'b00010, 0, 0, 5'b00000, 0, 5'b00010, 1, 3, 5'b00000, 0});
        tbl.push_back('{0, 5'b00000, 1, 1, 5'b00000, 0, 5'b00010, 1, 2, 5'b00000, 0});
        tbl.push_back('{0, 5'b00000, 1, 1, 5'b00000, 0, 5'b00010, 1, 1, 5'b00000, 0});
        tbl.push_back('{0, 5'b00000, 1, 1, 5'b00000, 0, 5'b00000, 0, 0, 5'b00000, 0});
        tbl.push_back('{0, 5'b00000, 6, 1, 5'b00000, 0, 5'b00000, 0, 0, 5'b00000, 1});
        tbl.push_back('{0, 5'b01000, 1, 1, 5'b00000, 0, 5'b01000, 1, 1, 5'b00000, 1});
        tbl.push_back('{0, 5'b00000, 0, 0, 5'b00000, 1, 5'b01000, 1, 1, 5'b00000, 0});
        tbl.push_back('{0, 5'b00001, 3, 1, 5'b00000, 1, 5'b00001, 1, 1, 5'b00000, 0});
        tbl.push_back('{0, 5'b10000, 4, 0, 5'b00000, 0, 5'b10001, 1, 2, 5'b00000, 0});
        tbl.push_back('{0, 5'b00000, 4, 1, 5'b00000, 0, 5'b00001, 1, 1, 5'b00000, 0});
        tbl.push_back('{0, 5'b00001, 0, 1, 5'b00000, 0, 5'b00001, 1, 1, 5'b00000, 0});
        tbl.push_back('{0, 5'b00000, 7, 1, 5'b00000, 1, 5'b00001, 1, 1, 5'b00000, 1});
        tbl.push_back('{0, 5'b00000, 0, 0, 5'b00000, 1, 5'b00001, 1, 1, 5'b00000, 0});
        tbl.push_back('{0, 5'b11111, 0, 0, 5'b00000, 0, 5'b11111, 1, 6, 5'b00000, 0});
        tbl.push_back('{1, 5'b11111, 0, 1, 5'b00000, 1, 5'b00000, 0, 0, 5'b00000, 0});

        foreach (tbl[k]) begin
            step(tbl[k].rst, tbl[k].pulse, tbl[k].gnum,
                 tbl[k].gval, tbl[k].oclr, tbl[k].eclr);
            check($sformatf("vec%0d", k), tbl[k].req, tbl[k].rval,
                  tbl[k].tot, tbl[k].ovf, tbl[k].err);
        end

        // saturation of requester 0 and sticky overflow
        step(1, '0, 0, 0, '0, 0);
        for (int i = 0; i < 15; i++) step(0, 5'b00001, 0, 0, '0, 0);
        check("sat15", 5'b00001, 1, 15, 5'b00000, 0);
        step(0, 5'b00001, 0, 0, '0, 0);
        check("sat16_ovf", 5'b00001, 1, 15, 5'b00001, 0);
        step(0, 5'b00000, 0, 0, 5'b00001, 0);
        check("ovf_clr", 5'b00001, 1, 15, 5'b00000, 0);
        step(0, 5'b00001, 0, 0, 5'b00001, 0);
        check("ovf_set_wins", 5'b00001, 1, 15, 5'b00001, 0);
        step(0, 5'b00000, 0, 0, 5'b00001, 0);
        check("ovf_clr2", 5'b00001, 1, 15, 5'b00000, 0);

        // requester 2 at MAX: pulse plus grant holds the count
        step(1, '0, 0, 0, '0, 0);
        for (int i = 0; i < 15; i++) step(0, 5'b00100, 0, 0, '0, 0);
        check("r2_max", 5'b00100, 1, 15, 5'b00000, 0);
        step(0, 5'b00100, 2, 1, '0, 0);
        check("r2_pulse_grant", 5'b00100, 1, 15, 5'b00000, 0);
        step(0, 5'b00000, 2, 1, '0, 0);
        check("r2_grant", 5'b00100, 1, 14, 5'b00000, 0);

        // reset mid-operation, then normal acceptance
        step(1, '0, 0, 0, '0, 0);
        for (int i = 0; i < 4; i++) step(0, 5'b11111, 0, 0, '0, 0);
        check("all4", 5'b11111, 1, 20, 5'b00000, 0);
        step(1, '0, 0, 0, '0, 0);
        check("mid_reset", 5'b00000, 0, 0, 5'b00000, 0);
        step(0, 5'b00010, 0, 0, '0, 0);
        check("post_reset", 5'b00010, 1, 1, 5'b00000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, fails);
        $finish;
    end

endmodule
